// File: rtl/csi_defuzzer.sv
// ---------------------------------------------------------------------------
// csi_defuzzer
// Receive-side inverse of the TX CSI fuzzer. It removes a known two-tap
// complex multipath (taps at delay 2 and delay 3) from the RX IQ stream with
// a recursive IIR:
//    y[n] = sat(x[n] - T1(y[n-2]) - T2(y[n-3]))
// Tap gains and rot90 flags are latched into shadow registers on pkt_start.
// The filter is valid-gated, has one cycle of latency, saturates its output
// and counts saturated samples.
//
// Ports
//   clk                  sole clock, rising edge
//   rstn                 asynchronous active-low reset
//   iq                   input sample, I in [D-1:0], Q in [2D-1:D]
//   iq_valid             input sample strobe
//   enable               1 = inverse filter, 0 = bypass (iq_out = iq)
//   pkt_start            one-cycle pulse: latch gains, clear history
//   bb_gain1/_rot90_flag tap-1 (delay 2) gain g/2^W, optional multiply by +j
//   bb_gain2/_rot90_flag tap-2 (delay 3) gain g/2^W, optional multiply by +j
//   iq_out               output sample, packed like iq
//   iq_out_valid         one-cycle strobe per input valid
//   sat_count            saturated outputs since pkt_start, sticks at 0xFFFF
// ---------------------------------------------------------------------------
module csi_defuzzer #(
   parameter int CSI_FUZZER_WIDTH = 6,
   parameter int IQ_DATA_WIDTH    = 16
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic [2*IQ_DATA_WIDTH-1:0]          iq,
   input  logic                                iq_valid,
   input  logic                                enable,
   input  logic                                pkt_start,
   input  logic signed [CSI_FUZZER_WIDTH-1:0]  bb_gain1,
   input  logic                                bb_gain1_rot90_flag,
   input  logic signed [CSI_FUZZER_WIDTH-1:0]  bb_gain2,
   input  logic                                bb_gain2_rot90_flag,
   output logic [2*IQ_DATA_WIDTH-1:0]          iq_out,
   output logic                                iq_out_valid,
   output logic [15:0]                         sat_count
);

   localparam int W = CSI_FUZZER_WIDTH;
   localparam int D = IQ_DATA_WIDTH;

   typedef struct packed {
      logic signed [D-1:0] q;
      logic signed [D-1:0] i;
   } cplx_t;

   // (v * g) >>> W, floor rounding. The full product fits in W+D bits for
   // every legal operand, including v = +2^(D-1) from an exact negation.
   function automatic logic signed [D-1:0] mul_shift(input logic signed [D:0]   v,
                                                     input logic signed [W-1:0] g);
      logic signed [W+D-1:0] prod;
      prod = $signed({{(W-1){v[D]}}, v}) * $signed({{D{g[W-1]}}, g});
      return D'(prod >>> W);
   endfunction

   function automatic cplx_t tap(input cplx_t v, input logic signed [W-1:0] g, input logic rot);
      cplx_t        t;
      logic [D:0]   neg_q;
      // Negate at D+1 bits so that -(-2^(D-1)) does not wrap.
      neg_q = -{v.q[D-1], v.q};
      if (rot) begin
         t.i = mul_shift(neg_q, g);
         t.q = mul_shift({v.i[D-1], v.i}, g);
      end else begin
         t.i = mul_shift({v.i[D-1], v.i}, g);
         t.q = mul_shift({v.q[D-1], v.q}, g);
      end
      return t;
   endfunction

   // Returns {clipped, saturated value}.
   function automatic logic [D:0] saturate(input logic [D+1:0] s);
      logic clip;
      clip = !((s[D+1:D-1] == '0) || (s[D+1:D-1] == '1));
      if (!clip)      return {1'b0, s[D-1:0]};
      else if (s[D+1]) return {1'b1, 1'b1, {(D-1){1'b0}}};
      else             return {1'b1, 1'b0, {(D-1){1'b1}}};
   endfunction

   // Shadow gains and filter history.
   logic signed [W-1:0] g1, g2;
   logic                r1, r2;
   cplx_t               y1, y2;    // y[n-1], y[n-2] relative to the sample arriving now
   cplx_t               p1, p2;    // pre-computed T1(y[n-2]), T2(y[n-3])

   cplx_t      x, y, t1, t2;
   logic [D+1:0] sum_i, sum_q;
   logic [D:0]   sat_i, sat_q;
   logic         clip;

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      x     = cplx_t'(iq);
      t1    = tap(y1, g1, r1);
      t2    = tap(y2, g2, r2);
      sum_i = {{2{x.i[D-1]}}, x.i} - {{2{p1.i[D-1]}}, p1.i} - {{2{p2.i[D-1]}}, p2.i};
      sum_q = {{2{x.q[D-1]}}, x.q} - {{2{p1.q[D-1]}}, p1.q} - {{2{p2.q[D-1]}}, p2.q};
      sat_i = saturate(sum_i);
      sat_q = saturate(sum_q);
      y     = x;
      clip  = 1'b0;
      if (enable) begin
         y.i  = sat_i[D-1:0];
         y.q  = sat_q[D-1:0];
         clip = sat_i[D] | sat_q[D];
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         g1           <= '0;
         g2           <= '0;
         r1           <= 1'b0;
         r2           <= 1'b0;
         y1           <= '0;
         y2           <= '0;
         p1           <= '0;
         p2           <= '0;
         iq_out       <= '0;
         iq_out_valid <= 1'b0;
         sat_count    <= '0;
      end else begin
         iq_out_valid <= iq_valid;
         if (pkt_start) begin
            g1        <= bb_gain1;
            g2        <= bb_gain2;
            r1        <= bb_gain1_rot90_flag;
            r2        <= bb_gain2_rot90_flag;
            sat_count <= '0;
            // A coincident sample sees zero history, so it passes as y = x and
            // both tap terms computed from that history are zero.
            y1        <= iq_valid ? x : '0;
            y2        <= '0;
            p1        <= '0;
            p2        <= '0;
            if (iq_valid) iq_out <= x;
         end else if (iq_valid) begin
            y1     <= y;
            y2     <= y1;
            p1     <= t1;
            p2     <= t2;
            iq_out <= y;
            if (clip && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_csi_defuzzer.sv
// ---------------------------------------------------------------------------
// tb_csi_defuzzer
// Directed bench for csi_defuzzer: reset, bypass, impulse responses, rot90,
// saturation, pkt_start with a coincident sample, mid-stream reset, and a
// random round trip through a forward fuzzer model.
// ---------------------------------------------------------------------------
module tb_csi_defuzzer;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic [31:0]       iq = '0;
   logic              iq_valid = 1'b0;
   logic              enable = 1'b0;
   logic              pkt_start = 1'b0;
   logic signed [5:0] bb_gain1 = '0;
   logic              bb_gain1_rot90_flag = 1'b0;
   logic signed [5:0] bb_gain2 = '0;
   logic              bb_gain2_rot90_flag = 1'b0;
   logic [31:0]       iq_out;
   logic              iq_out_valid;
   logic [15:0]       sat_count;

   int errors = 0;
   int checks = 0;

   csi_defuzzer dut (
      .clk                 (clk),
      .rstn                (rstn),
      .iq                  (iq),
      .iq_valid            (iq_valid),
      .enable              (enable),
      .pkt_start           (pkt_start),
      .bb_gain1            (bb_gain1),
      .bb_gain1_rot90_flag (bb_gain1_rot90_flag),
      .bb_gain2            (bb_gain2),
      .bb_gain2_rot90_flag (bb_gain2_rot90_flag),
      .iq_out              (iq_out),
      .iq_out_valid        (iq_out_valid),
      .sat_count           (sat_count)
   );

   always #5 clk = ~clk;

   function automatic int out_i();
      return int'($signed(iq_out[15:0]));
   endfunction

   function automatic int out_q();
      return int'($signed(iq_out[31:16]));
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_near(input string tag, input int obs, input int exp);
      checks++;
      assert ((obs - exp <= 2) && (exp - obs <= 2))
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d (+-2)", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, then return 1 time unit after the edge.
   task automatic step(input int xi, input int xq, input logic v, input logic ps);
      iq        = {16'(xq), 16'(xi)};
      iq_valid  = v;
      pkt_start = ps;
      @(posedge clk);
      #1;
      iq_valid  = 1'b0;
      pkt_start = 1'b0;
   endtask

   // Forward fuzzer tap term, floor division by 64.
   function automatic int tapv(input int vi, input int vq, input int g, input bit rot, input bit want_q);
      if (!rot) return want_q ? ((vq * g) >>> 6) : ((vi * g) >>> 6);
      else      return want_q ? ((vi * g) >>> 6) : ((-vq * g) >>> 6);
   endfunction

   int exp_imp [5] = '{1000, 0, -250, 0, 63};
   int in_imp  [5] = '{1000, 0, 0, 0, 0};
   int xi_s [200];
   int xq_s [200];

   initial begin
      // Reset state
      #2;
      check("reset_iq_out", int'(iq_out), 0);
      check("reset_valid", int'(iq_out_valid), 0);
      check("reset_sat", int'(sat_count), 0);
      #2 rstn = 1'b1;
      @(posedge clk); #1;

      // Bypass
      enable = 1'b0;
      step(1234, -5, 1'b1, 1'b0);
      check("bypass_i", out_i(), 1234);
      check("bypass_q", out_q(), -5);
      check("bypass_valid", int'(iq_out_valid), 1);
      check("bypass_sat", int'(sat_count), 0);
      step(7, 7, 1'b0, 1'b0);
      check("idle_valid_low", int'(iq_out_valid), 0);
      check("idle_hold_i", out_i(), 1234);

      // Impulse through tap 1 (G1 = 16 -> 0.25); gain input changes after
      // pkt_start must not reach the shadows.
      enable = 1'b1;
      bb_gain1 = 6'sd16; bb_gain1_rot90_flag = 1'b0;
      bb_gain2 = 6'sd0;  bb_gain2_rot90_flag = 1'b0;
      step(0, 0, 1'b0, 1'b1);
      bb_gain1 = 6'sd0;
      for (int k = 0; k < 5; k++) begin
         step(in_imp[k], 0, 1'b1, 1'b0);
         check($sformatf("impulse_i[%0d]", k), out_i(), exp_imp[k]);
         check($sformatf("impulse_q[%0d]", k), out_q(), 0);
      end

      // Rot90 on tap 1
      bb_gain1 = 6'sd16; bb_gain1_rot90_flag = 1'b1;
      step(0, 0, 1'b0, 1'b1);
      step(1000, 0, 1'b1, 1'b0);
      check("rot_first_i", out_i(), 1000);
      step(0, 0, 1'b1, 1'b0);
      step(0, 0, 1'b1, 1'b0);
      check("rot_third_i", out_i(), 0);
      check("rot_third_q", out_q(), -250);

      // Saturation with G1 = -32
      bb_gain1 = -6'sd32; bb_gain1_rot90_flag = 1'b0;
      step(0, 0, 1'b0, 1'b1);
      step(30000, 0, 1'b1, 1'b0);
      check("sat_first_i", out_i(), 30000);
      check("sat_first_cnt", int'(sat_count), 0);
      step(0, 0, 1'b1, 1'b0);
      step(30000, 0, 1'b1, 1'b0);
      check("sat_third_i", out_i(), 32767);
      check("sat_third_cnt", int'(sat_count), 1);

      // pkt_start coincident with a sample: history cleared, new gains used
      bb_gain1 = 6'sd16;
      step(1000, 0, 1'b1, 1'b1);
      check("pkv_first_i", out_i(), 1000);
      check("pkv_sat_cleared", int'(sat_count), 0);
      step(0, 0, 1'b1, 1'b0);
      check("pkv_second_i", out_i(), 0);
      step(0, 0, 1'b1, 1'b0);
      check("pkv_third_i", out_i(), -250);

      // Mid-stream reset: outputs clear at once, gains return to zero
      step(500, 0, 1'b1, 1'b0);
      rstn = 1'b0;
      #1;
      check("rst_mid_iq_out", int'(iq_out), 0);
      check("rst_mid_valid", int'(iq_out_valid), 0);
      #3 rstn = 1'b1;
      @(posedge clk); #1;
      step(1000, 0, 1'b1, 1'b0);
      check("rst_first_i", out_i(), 1000);
      step(0, 0, 1'b1, 1'b0);
      step(0, 0, 1'b1, 1'b0);
      check("rst_third_i", out_i(), 0);

      // Round trip: forward fuzzer model, then the defuzzer with matched taps
      for (int n = 0; n < 200; n++) begin
         xi_s[n] = int'($urandom_range(20000)) - 10000;
         xq_s[n] = int'($urandom_range(20000)) - 10000;
      end
      bb_gain1 = 6'sd20;  bb_gain1_rot90_flag = 1'b1;
      bb_gain2 = -6'sd12; bb_gain2_rot90_flag = 1'b0;
      step(0, 0, 1'b0, 1'b1);
      for (int n = 0; n < 200; n++) begin
         int zi, zq;
         zi = xi_s[n];
         zq = xq_s[n];
         if (n >= 2) begin
            zi += tapv(xi_s[n-2], xq_s[n-2], 20, 1'b1, 1'b0);
            zq += tapv(xi_s[n-2], xq_s[n-2], 20, 1'b1, 1'b1);
         end
         if (n >= 3) begin
            zi += tapv(xi_s[n-3], xq_s[n-3], -12, 1'b0, 1'b0);
            zq += tapv(xi_s[n-3], xq_s[n-3], -12, 1'b0, 1'b1);
         end
         repeat ($urandom_range(2)) step(0, 0, 1'b0, 1'b0);
         step(zi, zq, 1'b1, 1'b0);
         check_near($sformatf("rt_i[%0d]", n), out_i(), xi_s[n]);
         check_near($sformatf("rt_q[%0d]", n), out_q(), xq_s[n]);
      end
      check("rt_sat_count", int'(sat_count), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/csi_defuzzer.md
# csi_defuzzer

Receive-side inverse of the TX CSI fuzzer: removes a known 2-tap (delay-2 / delay-3) complex multipath from the RX IQ stream with a recursive IIR, so that a link can undo, or verify, fuzzed CSI. It sits in the RX baseband path ahead of the OFDM receiver. It takes the same gain and rot90 controls as the fuzzer, latched per packet. It is valid-gated, has one cycle of latency, saturates its output, and counts saturation events.

## Interface
- CSI_FUZZER_WIDTH, 6, signed tap gain width W; the gain is a fraction g/2^W.
- IQ_DATA_WIDTH, 16, signed I/Q component width D.
- clk  in  1  sole clock; all logic on the rising edge.
- rstn  in  1  reset, asynchronous assert, active-low; clears all state.
- iq  in  2D  input sample; I in [D-1:0], Q in [2D-1:D].
- iq_valid  in  1  input sample strobe.
- enable  in  1  1 = inverse filter, 0 = bypass.
- pkt_start  in  1  one-cycle pulse; latches the gains and clears the history.
- bb_gain1  in  W  signed gain of tap 1 (delay 2).
- bb_gain1_rot90_flag  in  1  multiply the tap-1 term by +j.
- bb_gain2  in  W  signed gain of tap 2 (delay 3).
- bb_gain2_rot90_flag  in  1  multiply the tap-2 term by +j.
- iq_out  out  2D  output sample, packed like iq.
- iq_out_valid  out  1  output strobe.
- sat_count  out  16  saturated output samples since the last pkt_start; sticks at 0xFFFF.

## Operation
- Shadow registers G1, R1, G2, R2 load from the gain inputs only on pkt_start. The shadows reset to 0.
- Recursion, per component, on complex samples: y[n] = sat(x[n] - T1(y[n-2]) - T2(y[n-3])).
- Tap term T(v), rot flag 0: I = (vI*G)>>>W, Q = (vQ*G)>>>W.
- Tap term T(v), rot flag 1: I = (-vQ*G)>>>W, Q = (vI*G)>>>W.
- Products are full W+D bits. The shift is arithmetic, so it floors toward negative infinity. The result keeps bits [W+D-1:W].
- Negation is done at D+1 bits, so that -(-2^(D-1)) is exact.
- Sum width D+2. Saturate to [-2^(D-1), 2^(D-1)-1].
- The feedback history is the saturated y, never the pre-saturation sum.
- Pipelining: on valid sample n, register p1 <= T1(y[n-1]) and p2 <= T2(y[n-2]). Sample n+1 then needs only x - p1 - p2, so the feedback path has no multiplier.
- History (y[n-1], y[n-2], p1, p2) advances only on iq_valid. Gaps in iq_valid are transparent.
- pkt_start clears the history, p1, p2 and sat_count to 0.
- pkt_start together with iq_valid in the same cycle: the clear and latch apply first. That sample uses the new gains with zero history, so y = x.
- enable=0: iq_out = iq on each valid, no saturation, sat_count frozen. The history still updates with y = x, so re-enabling mid-packet is glitch-free.
- Changing enable or the gain inputs outside pkt_start has no effect on the shadows.
- sat_count increments once per output sample where I or Q clipped, regardless of whether one or both clipped.

## Timing
- Reset values: iq_out = 0, iq_out_valid = 0, sat_count = 0, history = 0, shadows = 0.
- Latency: iq_out and iq_out_valid are registered 1 cycle after the iq_valid edge.
- iq_out_valid is high exactly one cycle per input valid.
- iq_out holds its last value while iq_out_valid is low.
- Back-to-back iq_valid is sustained at full rate (1 sample/cycle).
- sat_count updates in the same cycle as the corresponding iq_out.
- rstn asserted mid-packet: all outputs go to their reset values immediately. The first valid after release behaves like post-pkt_start with zero gains (y = x).

## Test plan
- Bypass: enable=0, iq={Q=-5, I=1234} with valid → next cycle iq_out={-5,1234}, iq_out_valid=1, sat_count=0.
- Impulse, G1=16, R1=0, G2=0, pkt_start, then I inputs 1000,0,0,0,0 on consecutive valids → I out 1000,0,-250,0,63. Q out all 0.
- Rot90, G1=16, R1=1, pkt_start, then I inputs 1000,0,0,0 → third output I=0, Q=-250.
- Saturation, G1=-32, pkt_start, then I inputs 30000,0,30000 → third output I=32767, sat_count=1. Next pkt_start → sat_count=0.
- Round trip: random 200-sample stream through csi_fuzzer (G1=20, G2=-12, mixed rot flags), then into csi_defuzzer with matched settings. With delays aligned, the output equals the original stream within ±2 LSB, with random iq_valid gaps.
- Simultaneous pkt_start+iq_valid, and rstn pulsed mid-stream: after either event, the first sample out equals its input, and the gains take their post-event values.
